// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding HI/LO: shift-add MULT/MULTU, restoring DIV/DIVU.
// Result written 33 edges after an accepted start; start is ignored while busy, MTHI/MTLO write in one edge.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs_in,
  input  logic [WIDTH-1:0] rt_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  logic               is_md;
  logic               is_div_op;
  logic               op_signed;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    is_div_op = (func == F_DIV) || (func == F_DIVU);
    is_md     = is_div_op || (func == F_MULT) || (func == F_MULTU);
    op_signed = (func == F_MULT) || (func == F_DIV);
    rs_neg    = op_signed & rs_in[WIDTH-1];
    rt_neg    = op_signed & rt_in[WIDTH-1];
    rs_mag    = rs_neg ? -rs_in : rs_in;
    rt_mag    = rt_neg ? -rt_in : rt_in;
    // acc:mq is the running product (mult) or remainder:dividend/quotient (div)
    addend    = mq[0] ? opnd : '0;
    mul_sum   = {1'b0, acc} + {1'b0, addend};
    div_shift = {acc, mq[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    prod      = {acc, mq};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_md) begin
              state    <= RUN;
              cnt      <= '0;
              acc      <= '0;
              is_div   <= is_div_op;
              mq       <= is_div_op ? rs_mag : rt_mag;
              opnd     <= is_div_op ? rt_mag : rs_mag;
              neg_q    <= rs_neg ^ rt_neg;
              neg_r    <= rs_neg;
              div_zero <= (rt_in == '0);
            end else if (func == F_MTHI) begin
              hi <= rs_in;
            end else if (func == F_MTLO) begin
              lo <= rs_in;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            // restoring step: keep the subtraction only when it did not borrow
            if (!div_diff[WIDTH]) begin
              acc <= div_diff[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_shift[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= mul_sum[WIDTH:1];
            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
          end
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            // divide by zero leaves acc = |rs|, so the remainder sign fix restores rs_in
            hi <= neg_r ? -acc : acc;
            lo <= div_zero ? '1 : (neg_q ? -mq : mq);
          end else begin
            {hi, lo} <= neg_q ? -prod : prod;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Table-driven bench for muldiv_unit with a result scoreboard and hand-written handshake/reset sequences.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   func;
  logic [W-1:0] rs_in;
  logic [W-1:0] rt_in;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .func  (func),
    .rs_in (rs_in),
    .rt_in (rt_in),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   func;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t            e;
    longint          sa;
    longint          sb;
    longint          q;
    longint          r;
    longint unsigned p;
    e.hi = '0;
    e.lo = '0;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    case (f)
      6'h18: begin
        p = sa * sb;
        {e.hi, e.lo} = p;
      end
      6'h19: begin
        p = {32'h0, a} * {32'h0, b};
        {e.hi, e.lo} = p;
      end
      6'h1A: begin
        if (b == '0) begin
          e.hi = a;
          e.lo = '1;
        end else begin
          q = sa / sb;
          r = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
      default: begin
        if (b == '0) begin
          e.hi = a;
          e.lo = '1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    func  = f;
    rs_in = a;
    rt_in = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    rs_in = $urandom;
    rt_in = $urandom;
    chk_b("busy_after_start", busy, 1'b1);
    chk_b("done_after_start", done, 1'b0);
  endtask

  task automatic wait_done(output int k, output int bad);
    bad = 0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (!busy) bad++;
    end
  endtask

  task automatic finish_op(input int pre, input string name);
    int   k;
    int   bad;
    exp_t e;
    wait_done(k, bad);
    chk({name, "_latency"}, pre + k, 33);
    chk({name, "_busy_gap"}, bad, 0);
    chk_b({name, "_busy_in_done"}, busy, 1'b0);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got empty queue expected entry", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_hi"}, hi, e.hi);
      chk({name, "_lo"}, lo, e.lo);
    end
  endtask

  initial begin
    int         pulses;
    int         bsy;
    logic [5:0] f;
    exp_t       e;

    vecs[0]  = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{6'h18, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{6'h1B, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
    vecs[4]  = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{6'h1A, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
    vecs[6]  = '{6'h1B, 32'hFFFFFFFF, 32'h00000007, 32'h00000003, 32'h24924924};
    vecs[7]  = '{6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{6'h18, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[10] = '{6'h19, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    for (int i = 11; i < NVEC; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      vecs[i].func = f;
      vecs[i].rs   = $urandom;
      vecs[i].rt   = (f >= 6'h1A) ? 32'($urandom_range(1, 1000)) : $urandom;
      e = model(f, vecs[i].rs, vecs[i].rt);
      vecs[i].exp_hi = e.hi;
      vecs[i].exp_lo = e.lo;
    end

    reset = 1'b1;
    start = 1'b0;
    func  = '0;
    rs_in = '0;
    rt_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_b("reset_busy", busy, 1'b0);
    chk_b("reset_done", done, 1'b0);
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    @(negedge clk);
    reset = 1'b0;

    // consecutive vectors start in the previous done cycle
    for (int i = 0; i < NVEC; i++) begin
      sb_q.push_back('{vecs[i].exp_hi, vecs[i].exp_lo});
      issue(vecs[i].func, vecs[i].rs, vecs[i].rt);
      finish_op(0, $sformatf("vec%0d", i));
    end

    // DIVU request during a MULT must be dropped
    sb_q.push_back('{32'h0, 32'h6});
    issue(6'h18, 32'd2, 32'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    func  = 6'h1B;
    rs_in = 32'd9;
    rt_in = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_op(5, "mult_ignore");
    pulses = 0;
    bsy    = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
      if (busy) bsy++;
    end
    chk("ignored_start_done_pulses", pulses, 0);
    chk("ignored_start_busy_cycles", bsy, 0);
    chk("ignored_start_hi", hi, 32'h0);
    chk("ignored_start_lo", lo, 32'h6);

    @(negedge clk);
    start = 1'b1;
    func  = 6'h11;
    rs_in = 32'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'h6);
    chk_b("mthi_busy", busy, 1'b0);
    chk_b("mthi_done", done, 1'b0);

    @(negedge clk);
    start = 1'b1;
    func  = 6'h13;
    rs_in = 32'h5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h5678);
    chk("mtlo_hi", hi, 32'h1234);
    chk_b("mtlo_busy", busy, 1'b0);

    @(negedge clk);
    start = 1'b1;
    func  = 6'h10;
    rs_in = 32'hDEADBEEF;
    rt_in = 32'h3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_b("badfunc_busy", busy, 1'b0);
    chk("badfunc_hi", hi, 32'h1234);
    chk("badfunc_lo", lo, 32'h5678);

    // reset in the middle of RUN must abort without a result
    issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_done", done, 1'b0);
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    bsy    = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
      if (busy) bsy++;
    end
    chk("abort_done_pulses", pulses, 0);
    chk("abort_busy_cycles", bsy, 0);
    chk("abort_hold_lo", lo, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
